pipe_sel_reg: RTL

PIPE_SEL_REG -- requirements
Module: pipe_sel_reg

---
 rtl/pipe_sel_reg.sv | 84 ++++++++
 1 files changed

// File: rtl/pipe_sel_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sel_reg
// Description : One-stage registered N:1 data selector with flush, stall and a
//               saturating start-up bubble counter that can zero early loads.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sel_reg #(
    parameter int WIDTH         = 64,
    parameter int NUM_IN        = 4,
    parameter int BUBBLE_CYCLES = 1,
    localparam int SEL_W        = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      flag,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    output logic [WIDTH-1:0]          result,
    output logic                      out_valid,
    output logic                      bubble_active
);

    localparam logic [7:0] C_BUBBLE_MAX = 8'(BUBBLE_CYCLES);

    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       bubble_cnt_q, bubble_cnt_d;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_bubble_active;

    assign w_bubble_active = (bubble_cnt_q < C_BUBBLE_MAX);

    // Out-of-range selects fall through to the zero default.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        result_d     = result_q;
        out_valid_d  = out_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            result_d    = '0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid_d = 1'b1;
                result_d    = (flag && w_bubble_active) ? '0 : w_sel_data;
                if (w_bubble_active) begin
                    bubble_cnt_d = bubble_cnt_q + 8'd1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q     <= '0;
            out_valid_q  <= 1'b0;
            bubble_cnt_q <= 8'd0;
        end else begin
            result_q     <= result_d;
            out_valid_q  <= out_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign result        = result_q;
    assign out_valid     = out_valid_q;
    assign bubble_active = w_bubble_active;

endmodule
`default_nettype wire
